// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that shares one memory interface unit between NREQ requesters.
// The payload is latched at grant time; a watchdog aborts transactions whose mem_done never arrives.
module mem_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 14,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_load,
    input  logic [NREQ-1:0]           req_store,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*16-1:0]        req_wdata,
    output logic [NREQ-1:0]           req_done,
    output logic                      req_err,
    output logic [7:0]                req_rdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      mem_load,
    output logic                      mem_store,
    output logic [AW-1:0]             mem_addr,
    output logic [15:0]               mem_wdata,
    input  logic                      mem_done,
    input  logic [7:0]                mem_data
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              load_q, load_d;
    logic              store_q, store_d;
    logic [15:0]       wd_q, wd_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   pend_s;
    logic              win_found_s;
    logic [IDW-1:0]    win_id_s;
    logic [IDW-1:0]    cand_s;
    logic [IDW-1:0]    win_next_s;

    // Round-robin search: first pending requester at or after rr_ptr wins.
    always_comb begin
        pend_s      = req_load | req_store;
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!win_found_s && pend_s[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_next_s = IDW'((int'(win_id_s) + 1) % NREQ);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        load_d   = load_q;
        store_d  = store_q;
        wd_d     = wd_q;
        done_d   = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d  = ST_ISSUE;
                    grant_d  = win_id_s;
                    addr_d   = req_addr[win_id_s*AW +: AW];
                    wdata_d  = req_wdata[win_id_s*16 +: 16];
                    // A simultaneous load and store serves the load; the store stays pending.
                    load_d   = req_load[win_id_s];
                    store_d  = ~req_load[win_id_s];
                    rr_ptr_d = win_next_s;
                    wd_d     = 16'd0;
                end else begin
                    load_d   = 1'b0;
                    store_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (mem_done) begin
                    rdata_d          = mem_data;
                    done_d[grant_q]  = 1'b1;
                    load_d           = 1'b0;
                    store_d          = 1'b0;
                    state_d          = ST_DONE;
                end else if (wd_q == 16'(TIMEOUT)) begin
                    rdata_d          = 8'd0;
                    done_d[grant_q]  = 1'b1;
                    err_d            = 1'b1;
                    load_d           = 1'b0;
                    store_d          = 1'b0;
                    state_d          = ST_DONE;
                end else begin
                    wd_d             = wd_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                load_d  = 1'b0;
                store_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                load_d  = 1'b0;
                store_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= 16'd0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            wd_q     <= 16'd0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            load_q   <= load_d;
            store_q  <= store_d;
            wd_q     <= wd_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    assign req_done  = done_q;
    assign req_err   = err_q;
    assign req_rdata = rdata_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign mem_load  = load_q;
    assign mem_store = store_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter with two requesters and TIMEOUT=8.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_load;
    logic [1:0]  req_store;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_done;
    logic        req_err;
    logic [7:0]  req_rdata;
    logic [0:0]  grant_id;
    logic        busy;
    logic        mem_load;
    logic        mem_store;
    logic [13:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [7:0]  mem_data;

    int checks   = 0;
    int failures = 0;

    mem_req_arbiter #(.NREQ(2), .AW(14), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_load  (req_load),
        .req_store (req_store),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .mem_load  (mem_load),
        .mem_store (mem_store),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_data  (mem_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req_load = 2'b00; req_store = 2'b00;
        req_addr = 28'd0; req_wdata = 32'd0; mem_done = 1'b0; mem_data = 8'h00;
        tick; tick;
        checks++; if ({mem_load, mem_store, busy, req_err} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_load, mem_store, busy, req_err}); end
        checks++; if (req_done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", req_done); end
        checks++; if ({mem_addr, mem_wdata, req_rdata, grant_id} !== 39'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, req_rdata, grant_id}); end
        reset_n = 1'b1;
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_load;
        req_addr[13:0] = 14'h10; req_load = 2'b01;
        tick;
        checks++; if (mem_load !== 1'b1 || mem_store !== 1'b0) begin failures++; $display("FAIL load_strobe got=%b%b exp=10", mem_load, mem_store); end
        checks++; if (mem_addr !== 14'h10) begin failures++; $display("FAIL load_addr got=%h exp=10", mem_addr); end
        checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL load_grant got=%b busy=%b exp=0/1", grant_id, busy); end
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (mem_load !== 1'b1 || req_done !== 2'b00) begin failures++; $display("FAIL load_hold cyc=%0d got=%b done=%b exp=1/00", c, mem_load, req_done); end
        end
        mem_done = 1'b1; mem_data = 8'h5A;
        tick;
        mem_done = 1'b0; mem_data = 8'h00; req_load = 2'b00;
        checks++; if (req_done !== 2'b01) begin failures++; $display("FAIL load_done got=%b exp=01", req_done); end
        checks++; if (req_rdata !== 8'h5A || req_err !== 1'b0) begin failures++; $display("FAIL load_rdata got=%h err=%b exp=5a/0", req_rdata, req_err); end
        checks++; if (mem_load !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL load_strobe_off got=%b busy=%b exp=0/1", mem_load, busy); end
        tick;
        checks++; if (req_done !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL load_end got=%b busy=%b exp=00/0", req_done, busy); end
    endtask

    task automatic test_single_store;
        req_addr[27:14] = 14'h12; req_wdata[31:16] = 16'hBEEF; req_store = 2'b10;
        tick;
        checks++; if (mem_store !== 1'b1 || mem_load !== 1'b0) begin failures++; $display("FAIL store_strobe got=%b%b exp=01", mem_load, mem_store); end
        checks++; if (mem_wdata !== 16'hBEEF || mem_addr !== 14'h12) begin failures++; $display("FAIL store_payload got=%h/%h exp=beef/12", mem_wdata, mem_addr); end
        checks++; if (grant_id !== 1'b1) begin failures++; $display("FAIL store_grant got=%b exp=1", grant_id); end
        mem_done = 1'b1;
        tick;
        mem_done = 1'b0; req_store = 2'b00;
        checks++; if (req_done !== 2'b10 || req_err !== 1'b0 || mem_store !== 1'b0) begin failures++; $display("FAIL store_done got=%b err=%b st=%b exp=10/0/0", req_done, req_err, mem_store); end
        tick;
    endtask

    task automatic test_back_to_back;
        int ngr; int cyc; int last_cyc; int exp_id; logic prev_ld;
        logic [13:0] exp_addr;
        req_addr = {14'h21, 14'h20}; req_load = 2'b11;
        ngr = 0; cyc = 0; last_cyc = 0; prev_ld = mem_load;
        while (ngr < 4 && cyc < 40) begin
            tick; cyc++;
            if (mem_load && !prev_ld) begin
                exp_id = ngr % 2;
                exp_addr = (exp_id == 0) ? 14'h20 : 14'h21;
                checks++; if (grant_id !== exp_id[0]) begin failures++; $display("FAIL b2b_grant n=%0d got=%0d exp=%0d", ngr, grant_id, exp_id); end
                checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL b2b_addr n=%0d got=%h exp=%h", ngr, mem_addr, exp_addr); end
                if (ngr > 0) begin
                    checks++; if (cyc - last_cyc != 3) begin failures++; $display("FAIL b2b_gap n=%0d got=%0d exp=3", ngr, cyc - last_cyc); end
                end
                last_cyc = cyc; ngr++;
            end
            prev_ld = mem_load;
            mem_done = mem_load;
        end
        checks++; if (ngr != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", ngr); end
        req_load = 2'b00; cyc = 0;
        while ((busy || mem_load) && cyc < 10) begin
            tick; mem_done = mem_load; cyc++;
        end
        mem_done = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain busy got=%b exp=0", busy); end
    endtask

    task automatic test_load_store;
        req_addr[13:0] = 14'h33; req_wdata[15:0] = 16'h1234;
        req_load = 2'b01; req_store = 2'b01;
        tick;
        checks++; if (mem_load !== 1'b1 || mem_store !== 1'b0 || grant_id !== 1'b0) begin failures++; $display("FAIL ls_first got=%b%b g=%b exp=10 g=0", mem_load, mem_store, grant_id); end
        mem_done = 1'b1;
        tick;
        mem_done = 1'b0; req_load = 2'b00;
        checks++; if (req_done !== 2'b01) begin failures++; $display("FAIL ls_first_done got=%b exp=01", req_done); end
        tick;
        checks++; if (busy !== 1'b0 || mem_store !== 1'b0) begin failures++; $display("FAIL ls_gap got=%b/%b exp=0/0", busy, mem_store); end
        tick;
        checks++; if (mem_store !== 1'b1 || mem_load !== 1'b0 || mem_wdata !== 16'h1234) begin failures++; $display("FAIL ls_second got=%b%b wd=%h exp=01 wd=1234", mem_load, mem_store, mem_wdata); end
        mem_done = 1'b1; mem_data = 8'hA5;
        tick;
        mem_done = 1'b0; req_store = 2'b00;
        checks++; if (req_done !== 2'b01 || req_rdata !== 8'hA5) begin failures++; $display("FAIL ls_second_done got=%b rd=%h exp=01/a5", req_done, req_rdata); end
        tick;
    endtask

    task automatic test_timeout;
        req_addr[27:14] = 14'h3F; req_load = 2'b10; mem_data = 8'hA5;
        tick;
        checks++; if (mem_load !== 1'b1 || grant_id !== 1'b1) begin failures++; $display("FAIL to_grant got=%b g=%b exp=1/1", mem_load, grant_id); end
        for (int k = 1; k <= 8; k++) begin
            tick;
            checks++; if (req_done !== 2'b00 || mem_load !== 1'b1) begin failures++; $display("FAIL to_wait k=%0d done=%b ld=%b exp=00/1", k, req_done, mem_load); end
        end
        tick;
        req_load = 2'b00;
        checks++; if (req_done !== 2'b10 || req_err !== 1'b1) begin failures++; $display("FAIL to_pulse done=%b err=%b exp=10/1", req_done, req_err); end
        checks++; if (req_rdata !== 8'h00 || mem_load !== 1'b0 || mem_store !== 1'b0) begin failures++; $display("FAIL to_outputs rd=%h ld=%b st=%b exp=00/0/0", req_rdata, mem_load, mem_store); end
        tick;
        checks++; if (busy !== 1'b0 || req_err !== 1'b0 || req_done !== 2'b00) begin failures++; $display("FAIL to_idle busy=%b err=%b done=%b exp=0/0/00", busy, req_err, req_done); end
        mem_data = 8'h00;
    endtask

    task automatic test_reset_mid;
        req_addr[13:0] = 14'h05; req_load = 2'b01;
        tick;
        checks++; if (mem_load !== 1'b1) begin failures++; $display("FAIL rst_mid_grant got=%b exp=1", mem_load); end
        tick; tick;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({mem_load, mem_store, busy, req_err, req_done} !== 6'd0) begin failures++; $display("FAIL rst_mid_ctrl got=%b exp=000000", {mem_load, mem_store, busy, req_err, req_done}); end
        checks++; if ({mem_addr, mem_wdata, req_rdata, grant_id} !== 39'd0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", {mem_addr, mem_wdata, req_rdata, grant_id}); end
        req_load = 2'b11;
        tick;
        checks++; if (req_done !== 2'b00) begin failures++; $display("FAIL rst_mid_nodone got=%b exp=00", req_done); end
        reset_n = 1'b1;
        tick;
        checks++; if (mem_load !== 1'b1 || grant_id !== 1'b0 || mem_addr !== 14'h05) begin failures++; $display("FAIL rst_mid_regrant ld=%b g=%b a=%h exp=1/0/05", mem_load, grant_id, mem_addr); end
        checks++; if (req_done !== 2'b00) begin failures++; $display("FAIL rst_mid_after got=%b exp=00", req_done); end
        req_load = 2'b00;
    endtask

    initial begin
        test_reset;
        test_single_load;
        test_single_store;
        test_back_to_back;
        test_load_store;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
